// File: rtl/pi_loop_filter.sv
// ADPLL phase detector and saturating PI loop filter feeding the DCO as sign/magnitude.
// Optional lock detector is built only when LOCK_DETECT_EN is defined.
module pi_loop_filter #(
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned INT_W    = 10,
    parameter int unsigned KP_SHIFT = 1,
    parameter int unsigned KI_SHIFT = 3,
    parameter int unsigned INT_FRAC = 2
`ifdef LOCK_DETECT_EN
    ,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned LOCK_CNT = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ref_clk,
    input  logic       fb_clk,
    output logic       ctrl_sign,
    output logic [4:0] ctrl,
    output logic       upd_valid,
    output logic       lock
);

    localparam int unsigned Y_W = 12;
    localparam logic [ERR_W-1:0] CntMax = {1'b0, {(ERR_W-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StLead, StLag, StUpdate} state_e;

    state_e                    state_q, state_d;
    logic        [2:0]         ref_sync_q, fb_sync_q;
    logic                      ref_p_q, fb_p_q;
    logic        [ERR_W-1:0]   cnt_q, cnt_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [INT_W-1:0]   integ_q;
    logic        [4:0]         ctrl_q;
    logic                      sign_q;
    logic                      upd_valid_q;

    logic signed [ERR_W-1:0]   err_kp, err_ki;
    logic signed [INT_W:0]     integ_sum;
    logic signed [INT_W-1:0]   integ_next, integ_sh;
    logic signed [Y_W-1:0]     y;
    logic        [Y_W-1:0]     y_abs;
    logic        [4:0]         ctrl_next;

    // Phase measurement: count clk cycles from the leading edge pulse to the lagging one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (ref_p_q && fb_p_q) begin
                    err_d   = '0;
                    state_d = StUpdate;
                end else if (ref_p_q) begin
                    cnt_d   = ERR_W'(1);
                    state_d = StLead;
                end else if (fb_p_q) begin
                    cnt_d   = ERR_W'(1);
                    state_d = StLag;
                end
            end
            StLead: begin
                if (fb_p_q || cnt_q == CntMax) begin
                    err_d   = $signed(cnt_q);
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q + ERR_W'(1);
                end
            end
            StLag: begin
                if (ref_p_q || cnt_q == CntMax) begin
                    err_d   = -$signed(cnt_q);
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q + ERR_W'(1);
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        err_kp    = err_q >>> KP_SHIFT;
        err_ki    = err_q >>> KI_SHIFT;
        integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(err_ki);
        // Top two bits disagreeing means the sum left the INT_W range.
        case (integ_sum[INT_W:INT_W-1])
            2'b01:   integ_next = {1'b0, {(INT_W-1){1'b1}}};
            2'b10:   integ_next = {1'b1, {(INT_W-1){1'b0}}};
            default: integ_next = integ_sum[INT_W-1:0];
        endcase
        integ_sh  = integ_next >>> INT_FRAC;
        y         = Y_W'(err_kp) + Y_W'(integ_sh);
        y_abs     = y[Y_W-1] ? -y : y;
        ctrl_next = (y_abs > Y_W'(31)) ? 5'd31 : y_abs[4:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
            ref_p_q     <= 1'b0;
            fb_p_q      <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            integ_q     <= '0;
            ctrl_q      <= '0;
            sign_q      <= 1'b0;
            upd_valid_q <= 1'b0;
        end else begin
            ref_sync_q  <= {ref_sync_q[1:0], ref_clk};
            fb_sync_q   <= {fb_sync_q[1:0], fb_clk};
            ref_p_q     <= ref_sync_q[1] & ~ref_sync_q[2];
            fb_p_q      <= fb_sync_q[1] & ~fb_sync_q[2];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            upd_valid_q <= (state_q == StUpdate);
            if (state_q == StUpdate) begin
                integ_q <= integ_next;
                ctrl_q  <= ctrl_next;
                sign_q  <= y[Y_W-1];
            end
        end
    end

`ifdef LOCK_DETECT_EN
    localparam int unsigned LC_W = $clog2(LOCK_CNT + 1);

    logic [LC_W-1:0]  lock_cnt_q;
    logic             lock_q;
    logic [ERR_W-1:0] err_abs;
    logic             in_win;

    always_comb begin
        err_abs = err_q[ERR_W-1] ? -err_q : err_q;
        in_win  = (err_abs <= ERR_W'(LOCK_TOL));
    end

    // lock is registered alongside ctrl so it changes with the upd_valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else if (state_q == StUpdate) begin
            if (in_win) begin
                if (lock_cnt_q != LC_W'(LOCK_CNT)) begin
                    lock_cnt_q <= lock_cnt_q + LC_W'(1);
                end
                lock_q <= (lock_cnt_q >= LC_W'(LOCK_CNT - 1));
            end else begin
                lock_cnt_q <= '0;
                lock_q     <= 1'b0;
            end
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    assign ctrl      = ctrl_q;
    assign ctrl_sign = sign_q;
    assign upd_valid = upd_valid_q;

endmodule

// File: tb/tb_pi_loop_filter.sv
// Randomized self-checking bench for pi_loop_filter against an arithmetic PI/lock model.
module tb_pi_loop_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ref_clk;
    logic       fb_clk;
    logic       ctrl_sign;
    logic [4:0] ctrl;
    logic       upd_valid;
    logic       lock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_integ = 0;
    int m_ctrl  = 0;
    int m_sign  = 0;
    int m_lock  = 0;
    int m_run   = 0;

    pi_loop_filter dut (
        .clk       (clk),
        .reset     (reset),
        .ref_clk   (ref_clk),
        .fb_clk    (fb_clk),
        .ctrl_sign (ctrl_sign),
        .ctrl      (ctrl),
        .upd_valid (upd_valid),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_integ = 0;
        m_ctrl  = 0;
        m_sign  = 0;
        m_lock  = 0;
        m_run   = 0;
    endtask

    task automatic model_update(input int err);
        int yv;
        m_integ = m_integ + (err >>> 3);
        if (m_integ > 511)  m_integ = 511;
        if (m_integ < -512) m_integ = -512;
        yv     = (err >>> 1) + (m_integ >>> 2);
        m_sign = (yv < 0) ? 1 : 0;
        m_ctrl = (yv < 0) ? -yv : yv;
        if (m_ctrl > 31) m_ctrl = 31;
`ifdef LOCK_DETECT_EN
        if (err >= -2 && err <= 2) m_run++;
        else                       m_run = 0;
        m_lock = (m_run >= 16) ? 1 : 0;
`else
        m_run  = 0;
        m_lock = 0;
`endif
    endtask

    // Drive rising edges at loop cycles t_ref / t_fb (-1 = not driven) and check the update.
    task automatic run_case(input int t_ref, input int t_fb, input int window,
                            input int exp_err, input int exp_lat, input string tag);
        int upd   = 0;
        int first = -1;
        int g_ctrl = 0, g_sign = 0, g_lock = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (upd_valid) begin
                upd++;
                if (first < 0) begin
                    first  = i;
                    g_ctrl = int'(ctrl);
                    g_sign = int'(ctrl_sign);
                    g_lock = int'(lock);
                end
            end
            if (i == t_ref) ref_clk = 1'b1;
            if (i == t_fb)  fb_clk  = 1'b1;
        end
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (upd_valid) upd++;
        end
        model_update(exp_err);
        check_eq({tag, "_npulse"}, upd, 1);
        check_eq({tag, "_latency"}, first, exp_lat);
        check_eq({tag, "_ctrl"}, g_ctrl, m_ctrl);
        check_eq({tag, "_sign"}, g_sign, m_sign);
        check_eq({tag, "_lock"}, g_lock, m_lock);
        check_eq({tag, "_hold"}, int'(ctrl), m_ctrl);
    endtask

    // d = fb edge time minus ref edge time, in clk cycles.
    task automatic pair(input int d, input string tag);
        int ad;
        ad = (d < 0) ? -d : d;
        if (d >= 0) run_case(0, d, ad + 12, d, d + 5, tag);
        else        run_case(ad, 0, ad + 12, d, ad + 5, tag);
    endtask

    task automatic single_ref(input string tag);
        run_case(0, -1, 140, 127, 132, tag);
    endtask

    task automatic single_fb(input string tag);
        run_case(-1, 0, 140, -127, 132, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_clk = (i < 3) ? ~ref_clk : 1'b0;
            fb_clk  = (i < 3) ? ((i % 2) == 0) : 1'b0;
            @(negedge clk);
            check_eq({tag, "_rst_ctrl"}, int'(ctrl), 0);
            check_eq({tag, "_rst_sign"}, int'(ctrl_sign), 0);
            check_eq({tag, "_rst_upd"}, int'(upd_valid), 0);
            check_eq({tag, "_rst_lock"}, int'(lock), 0);
        end
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        reset   = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int upd;
        int d;
        reset   = 1'b1;
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset with toggling inputs, then ref leads by 8
        do_reset("t1");
        pair(8, "t2");
        check_eq("t2_ctrl_abs", int'(ctrl), 4);
        check_eq("t2_sign_abs", int'(ctrl_sign), 0);

        do_reset("t3");
        pair(-20, "t3");
        check_eq("t3_ctrl_abs", int'(ctrl), 11);
        check_eq("t3_sign_abs", int'(ctrl_sign), 1);

        do_reset("t4");
        pair(0, "t4");
        check_eq("t4_ctrl_abs", int'(ctrl), 0);

        // Reset in the middle of a LEAD count must abort without an update
        @(negedge clk);
        ref_clk = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        ref_clk = 1'b0;
        model_reset();
        upd = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (upd_valid) upd++;
        end
        check_eq("t4_midlead_upd", upd, 0);
        check_eq("t4_midlead_ctrl", int'(ctrl), 0);

        // Timeouts drive the integrator into its clamp, then back down
        do_reset("t5");
        for (int k = 0; k < 36; k++) single_ref("t5_up");
        check_eq("t5_ctrl_sat", int'(ctrl), 31);
        check_eq("t5_sign_sat", int'(ctrl_sign), 0);
        for (int k = 0; k < 20; k++) single_fb("t5_dn");

        // Lock acquisition and loss
        do_reset("t6");
        for (int k = 0; k < 16; k++) pair(1, "t6_in");
`ifdef LOCK_DETECT_EN
        check_eq("t6_locked", int'(lock), 1);
`else
        check_eq("t6_nolock", int'(lock), 0);
`endif
        pair(5, "t6_out");
        check_eq("t6_unlocked", int'(lock), 0);

        // Randomized phase errors
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) single_ref("rnd_tref");
                else                           single_fb("rnd_tfb");
            end else begin
                d = int'($urandom_range(0, 254)) - 127;
                pair(d, "rnd");
            end
        end
        for (int k = 0; k < 8; k++) begin
            d = int'($urandom_range(0, 4)) - 2;
            pair(d, "rnd_small");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
